// File: rtl/spu_write_arbiter_pkg.sv
// Shared types and constants for the SPU i_next write arbiter.
package spu_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b01,
        ARB_ISSUE = 2'b10
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Width of an index into n requesters (at least 1 bit).
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int k = 1; k < 32; k++) begin
            if ((1 << k) < n) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spu_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index after last_grant, wrapping.
module spu_write_arbiter_rr_pick #(
    parameter int NUM_SPU = 4,
    parameter int PTRW    = 2
) (
    input  logic [NUM_SPU-1:0] valid,
    input  logic [PTRW-1:0]    last_grant,
    output logic [NUM_SPU-1:0] winner,
    output logic [PTRW-1:0]    win_idx,
    output logic               win_any
);

    // Scan farthest-to-nearest so the nearest valid index after last_grant wins.
    always_comb begin
        int idx_s;
        winner  = {NUM_SPU{1'b0}};
        win_idx = {PTRW{1'b0}};
        win_any = 1'b0;
        idx_s   = 0;
        for (int off = NUM_SPU; off >= 1; off--) begin
            idx_s = (int'(last_grant) + off) % NUM_SPU;
            if (valid[idx_s]) begin
                winner        = {NUM_SPU{1'b0}};
                winner[idx_s] = 1'b1;
                win_idx       = PTRW'(idx_s);
                win_any       = 1'b1;
            end else begin
                win_any = win_any;
            end
        end
    end

endmodule

// File: rtl/spu_write_arbiter.sv
// Round-robin arbiter from NUM_SPU one-cycle write pulses onto one i_next write port.
// Optional stall counter enabled by defining SPU_WRITE_ARB_STATS_EN.
module spu_write_arbiter
    import spu_write_arbiter_pkg::*;
#(
    parameter int NUM_SPU  = 4,
    parameter int NUMWIDTH = 16,
    parameter int TAGBITS  = 1
) (
    input  logic                            clk,
    input  logic                            asyn_reset_n,
    input  logic [NUM_SPU-1:0]              req_write_i_next,
    input  logic [NUM_SPU*(NUMWIDTH+1)-1:0] i_next_data,
    input  logic [NUM_SPU*TAGBITS-1:0]      dst_tag,
    input  logic                            mem_ready,
    output logic                            mem_we,
    output logic [TAGBITS-1:0]              mem_addr,
    output logic [NUMWIDTH:0]               mem_wdata,
    output logic [NUM_SPU-1:0]              grant,
    output logic [NUM_SPU-1:0]              pending,
    output logic                            overflow
`ifdef SPU_WRITE_ARB_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]          stall_count
`endif
);

    localparam int PTRW = clog2(NUM_SPU);

    arb_state_t            state_r, state_nxt_s;
    logic [NUM_SPU-1:0]    slot_valid_r;
    logic [NUMWIDTH:0]     slot_data_r [NUM_SPU];
    logic [TAGBITS-1:0]    slot_tag_r  [NUM_SPU];
    logic [NUM_SPU-1:0]    grant_r;
    logic [PTRW-1:0]       grant_idx_r, last_grant_r;
    logic                  mem_we_r, overflow_r;
    logic [TAGBITS-1:0]    mem_addr_r;
    logic [NUMWIDTH:0]     mem_wdata_r;

    logic                  accept_s, load_win_s, overflow_hit_s;
    logic [NUM_SPU-1:0]    acc_mask_s, pick_valid_s, win_onehot_s;
    logic [PTRW-1:0]       pick_last_s, win_idx_s;
    logic                  win_any_s;

    // While issuing, the slot being accepted is excluded and the search starts after it.
    always_comb begin
        accept_s = (state_r == ARB_ISSUE) && mem_ready;
        if (accept_s) begin
            acc_mask_s = grant_r;
        end else begin
            acc_mask_s = {NUM_SPU{1'b0}};
        end
        if (state_r == ARB_ISSUE) begin
            pick_valid_s = slot_valid_r & ~grant_r;
            pick_last_s  = grant_idx_r;
        end else begin
            pick_valid_s = slot_valid_r;
            pick_last_s  = last_grant_r;
        end
        overflow_hit_s = |(req_write_i_next & slot_valid_r & ~acc_mask_s);
    end

    spu_write_arbiter_rr_pick #(
        .NUM_SPU (NUM_SPU),
        .PTRW    (PTRW)
    ) u_rr_pick (
        .valid      (pick_valid_s),
        .last_grant (pick_last_s),
        .winner     (win_onehot_s),
        .win_idx    (win_idx_s),
        .win_any    (win_any_s)
    );

    // Next-state and winner-load decision.
    always_comb begin
        state_nxt_s = state_r;
        load_win_s  = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (win_any_s) begin
                    state_nxt_s = ARB_ISSUE;
                    load_win_s  = 1'b1;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (mem_ready && win_any_s) begin
                    load_win_s = 1'b1;
                end else if (mem_ready) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_ISSUE;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // FSM state, write-valid, round-robin pointer and sticky overflow.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_r      <= ARB_IDLE;
            mem_we_r     <= 1'b0;
            last_grant_r <= PTRW'(NUM_SPU - 1);
            overflow_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            mem_we_r <= (state_nxt_s == ARB_ISSUE);
            if (accept_s) begin
                last_grant_r <= grant_idx_r;
            end
            if (overflow_hit_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Write address/data/grant only move on a new winner or on the final acceptance.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            grant_r     <= {NUM_SPU{1'b0}};
            grant_idx_r <= {PTRW{1'b0}};
            mem_addr_r  <= {TAGBITS{1'b0}};
            mem_wdata_r <= {(NUMWIDTH+1){1'b0}};
        end else if (load_win_s) begin
            grant_r     <= win_onehot_s;
            grant_idx_r <= win_idx_s;
            mem_addr_r  <= slot_tag_r[win_idx_s];
            mem_wdata_r <= slot_data_r[win_idx_s];
        end else if (accept_s) begin
            grant_r <= {NUM_SPU{1'b0}};
        end
    end

    // Holding slots: a slot freed by acceptance this edge may be refilled on the same edge.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            slot_valid_r <= {NUM_SPU{1'b0}};
            for (int i = 0; i < NUM_SPU; i++) begin
                slot_data_r[i] <= {(NUMWIDTH+1){1'b0}};
                slot_tag_r[i]  <= {TAGBITS{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_SPU; i++) begin
                if (req_write_i_next[i] && (!slot_valid_r[i] || acc_mask_s[i])) begin
                    slot_valid_r[i] <= 1'b1;
                    slot_data_r[i]  <= i_next_data[i*(NUMWIDTH+1) +: (NUMWIDTH+1)];
                    slot_tag_r[i]   <= dst_tag[i*TAGBITS +: TAGBITS];
                end else if (acc_mask_s[i]) begin
                    slot_valid_r[i] <= 1'b0;
                end
            end
        end
    end

`ifdef SPU_WRITE_ARB_STATS_EN
    logic [STALL_CNT_W-1:0] stall_count_r;

    // Saturating count of cycles where a write is offered but not taken.
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            stall_count_r <= {STALL_CNT_W{1'b0}};
        end else if ((state_r == ARB_ISSUE) && !mem_ready && (stall_count_r != {STALL_CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_count = stall_count_r;
`endif

    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign grant     = grant_r;
    assign pending   = slot_valid_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_spu_write_arbiter.sv
// Self-checking bench for spu_write_arbiter against a slot/queue-level behavioural model.
module tb_spu_write_arbiter;

    localparam int N  = 4;
    localparam int NW = 16;
    localparam int TB = 2;
    localparam int W  = 1 + TB + (NW + 1) + N + N + 1;

    logic                   clk = 1'b0;
    logic                   asyn_reset_n = 1'b0;
    logic [N-1:0]           req = '0;
    logic [N*(NW+1)-1:0]    data = '0;
    logic [N*TB-1:0]        tag = '0;
    logic                   mem_ready = 1'b0;
    logic                   mem_we;
    logic [TB-1:0]          mem_addr;
    logic [NW:0]            mem_wdata;
    logic [N-1:0]           grant, pending;
    logic                   overflow;
`ifdef SPU_WRITE_ARB_STATS_EN
    logic [15:0]            stall_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    spu_write_arbiter #(.NUM_SPU(N), .NUMWIDTH(NW), .TAGBITS(TB)) dut (
        .clk              (clk),
        .asyn_reset_n     (asyn_reset_n),
        .req_write_i_next (req),
        .i_next_data      (data),
        .dst_tag          (tag),
        .mem_ready        (mem_ready),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .grant            (grant),
        .pending          (pending),
        .overflow         (overflow)
`ifdef SPU_WRITE_ARB_STATS_EN
        ,
        .stall_count      (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: slots, current owner, and the last accepted requester.
    bit          m_busy;
    int          m_owner, m_last, m_stall;
    bit          m_valid [N];
    logic [NW:0] m_data  [N];
    logic [TB-1:0] m_tag [N];
    bit          m_ovf;
    logic [TB-1:0] e_addr;
    logic [NW:0] e_wdata;

    wire [W-1:0] dut_vec = {mem_we, mem_addr, mem_wdata, grant, pending, overflow};

    function automatic logic [W-1:0] exp_vec();
        logic [N-1:0] g, p;
        g = '0;
        p = '0;
        if (m_busy) g[m_owner] = 1'b1;
        for (int i = 0; i < N; i++) p[i] = m_valid[i];
        return {m_busy, e_addr, e_wdata, g, p, m_ovf};
    endfunction

    function automatic int rr_search(int after, int excl);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (after + k) % N;
            if (m_valid[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = N - 1; m_stall = 0; m_ovf = 0;
        e_addr = '0; e_wdata = '0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_data[i] = '0; m_tag[i] = '0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        int ai, n;
        acc = m_busy && mem_ready;
        ai  = m_owner;
        if (m_busy && !mem_ready && m_stall < 65535) m_stall++;
        if (!m_busy) begin
            n = rr_search(m_last, -1);
            if (n >= 0) begin
                m_busy = 1; m_owner = n; e_addr = m_tag[n]; e_wdata = m_data[n];
            end
        end else if (acc) begin
            m_last = ai;
            n = rr_search(ai, ai);
            if (n >= 0) begin
                m_owner = n; e_addr = m_tag[n]; e_wdata = m_data[n];
            end else begin
                m_busy = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (!m_valid[i] || (acc && i == ai)) begin
                    m_valid[i] = 1;
                    m_data[i]  = data[i*(NW+1) +: (NW+1)];
                    m_tag[i]   = tag[i*TB +: TB];
                end else begin
                    m_ovf = 1;
                end
            end else if (acc && i == ai) begin
                m_valid[i] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        asyn_reset_n = 1'b0;
        req = '0; mem_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        asyn_reset_n = 1'b1;
    endtask

    task automatic set_slot(int i, logic [NW:0] d, logic [TB-1:0] t);
        req[i] = 1'b1;
        data[i*(NW+1) +: (NW+1)] = d;
        tag[i*TB +: TB] = t;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (dut_vec !== {W{1'b0}}) begin
            miscompares++;
            $display("FAIL reset: dut=%h required=%h", dut_vec, {W{1'b0}});
        end
`ifdef SPU_WRITE_ARB_STATS_EN
        vectors++;
        if (stall_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_stall: dut=%h required=0", stall_count);
        end
`endif
    endtask

    task automatic test_single();
        do_reset();
        mem_ready = 1'b1;
        set_slot(0, 17'h00123, 2'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            req = '0;
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL single c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
            end
            if (c == 1) begin
                vectors++;
                if ({mem_we, mem_addr, mem_wdata, grant} !== {1'b1, 2'd0, 17'h00123, 4'b0001}) begin
                    miscompares++;
                    $display("FAIL single_issue: we=%b addr=%h data=%h grant=%b", mem_we, mem_addr, mem_wdata, grant);
                end
            end
        end
    endtask

    task automatic test_all_four();
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < N; i++) set_slot(i, 17'(32'h100 + i), 2'(i));
        step();
        req = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL all_four c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
            end
            if (c < 4) begin
                vectors++;
                if ({mem_we, grant, mem_addr} !== {1'b1, 4'(1 << c), 2'(c)}) begin
                    miscompares++;
                    $display("FAIL all_four_order c%0d: we=%b grant=%b addr=%h", c, mem_we, grant, mem_addr);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        do_reset();
        set_slot(2, 17'h1ABCD, 2'd3);
        step();
        req = '0;
        step();
        held = dut_vec;
        for (int c = 0; c < 5; c++) begin
            step();
            vectors++;
            if (dut_vec !== exp_vec() || dut_vec !== held) begin
                miscompares++;
                $display("FAIL stall_hold c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
            end
        end
`ifdef SPU_WRITE_ARB_STATS_EN
        vectors++;
        if (stall_count !== 16'd5 || int'(stall_count) != m_stall) begin
            miscompares++;
            $display("FAIL stall_count: dut=%0d required=5", stall_count);
        end
`endif
        mem_ready = 1'b1;
        step();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL stall_release: dut=%h model=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        mem_ready = 1'b1;
        set_slot(1, 17'h0AAAA, 2'd1);
        step();
        set_slot(1, 17'h05555, 2'd2);
        step();
        req = '0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL overflow c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
            end
            if (c == 0) begin
                vectors++;
                if ({overflow, mem_we, mem_wdata} !== {1'b1, 1'b1, 17'h0AAAA}) begin
                    miscompares++;
                    $display("FAIL overflow_drop: ovf=%b we=%b data=%h", overflow, mem_we, mem_wdata);
                end
            end
            step();
        end
        do_reset();
        mem_ready = 1'b1;
        set_slot(1, 17'h0AAAA, 2'd1);
        step();
        req = '0;
        step();
        set_slot(1, 17'h05555, 2'd2);
        step();
        req = '0;
        vectors++;
        if ({overflow, pending, mem_we} !== {1'b0, 4'b0010, 1'b0} || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL reload_edge: ovf=%b pend=%b we=%b", overflow, pending, mem_we);
        end
        step();
        vectors++;
        if ({mem_we, mem_wdata, mem_addr, overflow} !== {1'b1, 17'h05555, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL reload_issue: we=%b data=%h addr=%h ovf=%b", mem_we, mem_wdata, mem_addr, overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_slot(i, 17'(32'h700 + i), 2'(i));
        step();
        req = '0;
        step();
        asyn_reset_n = 1'b0;
        #1;
        vectors++;
        if ({mem_we, pending, grant} !== {1'b0, 4'b0000, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_mid: we=%b pend=%b grant=%b required all zero", mem_we, pending, grant);
        end
        do_reset();
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (mem_we !== 1'b0 || dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_mid_after c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] prev;
        int n0, n2;
        do_reset();
        mem_ready = 1'b1;
        prev = '0; n0 = 0; n2 = 0;
        for (int c = 0; c < 24; c++) begin
            req = '0;
            for (int i = 0; i <= 2; i += 2) begin
                if (!m_valid[i] || (m_busy && m_owner == i)) set_slot(i, 17'($urandom), 2'($urandom));
            end
            step();
            vectors++;
            if (dut_vec !== exp_vec() || (grant != 4'b0000 && grant === prev)) begin
                miscompares++;
                $display("FAIL fairness c%0d: dut=%h model=%h prev_grant=%b", c, dut_vec, exp_vec(), prev);
            end
            if (grant == 4'b0001) n0++;
            if (grant == 4'b0100) n2++;
            if (grant != 4'b0000) prev = grant;
        end
        req = '0;
        vectors++;
        if (n0 < 8 || n2 < 8) begin
            miscompares++;
            $display("FAIL fairness_count: spu0=%0d spu2=%0d required >=8 each", n0, n2);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = '0;
            mem_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0 && (!m_valid[i] || $urandom_range(0, 15) == 0))
                    set_slot(i, 17'($urandom), 2'($urandom));
            end
            step();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL random c%0d: dut=%h model=%h", c, dut_vec, exp_vec());
            end
`ifdef SPU_WRITE_ARB_STATS_EN
            vectors++;
            if (int'(stall_count) != m_stall) begin
                miscompares++;
                $display("FAIL random_stall c%0d: dut=%0d model=%0d", c, stall_count, m_stall);
            end
`endif
        end
        req = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_four();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
